snn_neuron_scheduler: RTL
=========================

SNN_NEURON_SCHEDULER -- requirements
Module: snn_neuron_scheduler

Interface
REQ-001 SHALL have parameter N_NEURONS, default 4: number of virtual neurons sharing one accumulate/fire datapath.
REQ-002 SHALL have parameter W, default 8: membrane and input width.
REQ-003 SHALL have parameter LEAK, default 1: amount subtracted from a non-firing membrane each step.
REQ-004 SHALL have parameter REFRACT_STEPS, default 2: refractory length in steps; used only under REFRACTORY_EN.
REQ-005 SHALL have port clk  input  1: clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-007 SHALL have port step_valid  input  1: a new timestep's input vector is offered.
REQ-008 SHALL have port step_ready  output  1: high only in IDLE.
REQ-009 SHALL have port in_current  input  N_NEURONS*W: per-neuron input; neuron i occupies bits [i*W +: W].
REQ-010 SHALL have port threshold  input  W: firing threshold.
REQ-011 SHALL have port out_valid  output  1: spike_vec holds a completed step result.
REQ-012 SHALL have port out_ready  input  1: consumer accepts the result.
REQ-013 SHALL have port spike_vec  output  N_NEURONS: bit i set when neuron i fired this step.
REQ-014 SHALL have port busy  output  1: high whenever the state is not IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> UPDATE -> EMIT -> IDLE.
REQ-016 Step acceptance is the rising edge where step_valid && step_ready; in_current and threshold SHALL be captured on that edge and the FSM SHALL enter UPDATE with index 0 and spike_vec cleared.
REQ-017 In UPDATE, one neuron per cycle, index 0..N_NEURONS-1; neuron i SHALL be written on edge E0+1+i, where E0 is the acceptance edge.
REQ-018 Datapath: sum = mem[i] + in[i] in W+1 bits, saturated to 2^W-1.
REQ-019 Fire rule: if sum >= captured threshold, mem[i] <= 0 and spike_vec[i] <= 1; otherwise mem[i] <= max(sum - LEAK, 0).
REQ-020 Threshold 0 SHALL fire every neuron every step.
REQ-021 After the last neuron's update edge (E0+N_NEURONS), the FSM SHALL enter EMIT with out_valid=1.
REQ-022 In EMIT, out_valid and spike_vec SHALL hold stable until out_ready=1; on the edge with out_valid && out_ready the FSM SHALL return to IDLE and out_valid SHALL drop.
REQ-023 step_valid SHALL be ignored outside IDLE, and in_current and threshold changes SHALL have no effect after capture.
REQ-024 Throughput: one step per N_NEURONS+2 cycles minimum, with out_ready tied high.

Reset
REQ-025 While rst_n=0: all mem=0, state=IDLE, index=0, spike_vec=0, out_valid=0, busy=0, step_ready=1 after release.
REQ-026 Reset asserted mid-UPDATE or mid-EMIT SHALL discard the step; no partial result is emitted.

Configuration
REQ-027 Macro REFRACTORY_EN defined: each neuron SHALL have a refractory step counter loaded with REFRACT_STEPS on firing.
REQ-028 While a neuron's counter is nonzero: its input is ignored, mem stays 0, its spike bit is 0, and the counter decrements once per step.
REQ-029 Macro REFRACTORY_EN undefined: no counters exist and a neuron accumulates on the step immediately after firing.

Verification
REQ-030 After reset, in=[10,20,30,40], threshold=100 -> out_valid 4 cycles after acceptance, spike_vec=0000, mems 9,19,29,39.
REQ-031 Neuron0 in=200 for two steps, threshold=255 -> step1 mem=199, no spike; step2 sum saturates to 255 -> spike_vec[0]=1, mem0=0.
REQ-032 out_ready held low 10 cycles in EMIT with step_valid=1 -> spike_vec and out_valid stable, step_ready=0, no step accepted.
REQ-033 rst_n pulsed low during UPDATE index 2 -> all mems 0, out_valid never asserted, IDLE after release.
REQ-034 threshold=0, in=0 -> spike_vec=1111 every step.
REQ-035 REFRACTORY_EN, REFRACT_STEPS=2, neuron0 in=255, threshold=255 each step -> fires step1, silent steps 2-3, fires step4.

Source files
------------

// File: rtl/snn_neuron_scheduler.sv
// rtl/snn_neuron_scheduler.sv - time-multiplexed leaky integrate-and-fire neuron scheduler (optional REFRACTORY_EN)
module snn_neuron_scheduler #(
  parameter int N_NEURONS     = 4,
  parameter int W             = 8,
  parameter int LEAK          = 1,
  parameter int REFRACT_STEPS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   step_valid,
  output logic                   step_ready,
  input  logic [N_NEURONS*W-1:0] in_current,
  input  logic [W-1:0]           threshold,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_NEURONS-1:0]   spike_vec,
  output logic                   busy
);

  localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic [W:0] MAX_V  = {1'b0, {W{1'b1}}};
  localparam logic [W:0] LEAK_V = (W+1)'(LEAK);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_EMIT} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx;
  logic [W-1:0]         mem [N_NEURONS];
  logic [W-1:0]         cur [N_NEURONS];
  logic [W-1:0]         thr_q;
  logic [N_NEURONS-1:0] spikes;

  logic                 accept;
  logic                 in_refract;
  logic [W:0]           sum_raw;
  logic [W:0]           sum_sat;
  logic                 fire;
  logic [W-1:0]         mem_nxt;

  assign accept    = step_valid && (state == S_IDLE);
  assign spike_vec = spikes;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt  = state;
    step_ready = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        step_ready = 1'b1;
        busy       = 1'b0;
        if (step_valid) state_nxt = S_UPDATE;
      end
      S_UPDATE: begin
        if (idx == LAST_IDX) state_nxt = S_EMIT;
      end
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef REFRACTORY_EN
  localparam int RC_W = ($clog2(REFRACT_STEPS + 1) > 0) ? $clog2(REFRACT_STEPS + 1) : 1;
  logic [RC_W-1:0] rcnt [N_NEURONS];

  assign in_refract = (rcnt[idx] != '0);

  // Refractory counters: load on fire, count down once per step while silent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) rcnt[i] <= '0;
    end else if (state == S_UPDATE) begin
      if (in_refract)  rcnt[idx] <= rcnt[idx] - 1'b1;
      else if (fire)   rcnt[idx] <= RC_W'(REFRACT_STEPS);
    end
  end
`else
  assign in_refract = 1'b0;
`endif

  // Shared accumulate/leak/fire datapath for the neuron selected by idx
  always_comb begin
    sum_raw = {1'b0, mem[idx]} + {1'b0, cur[idx]};
    sum_sat = sum_raw[W] ? MAX_V : sum_raw;
    fire    = (sum_sat >= {1'b0, thr_q});
    mem_nxt = '0;
    if (!fire && (sum_sat > LEAK_V)) mem_nxt = W'(sum_sat - LEAK_V);
  end

  // Step capture, neuron index walk and membrane/spike write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      thr_q  <= '0;
      spikes <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        mem[i] <= '0;
        cur[i] <= '0;
      end
    end else if (accept) begin
      idx    <= '0;
      spikes <= '0;
      thr_q  <= threshold;
      for (int i = 0; i < N_NEURONS; i++) cur[i] <= in_current[i*W +: W];
    end else if (state == S_UPDATE) begin
      idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      if (in_refract) begin
        mem[idx]    <= '0;
        spikes[idx] <= 1'b0;
      end else begin
        mem[idx]    <= mem_nxt;
        spikes[idx] <= fire;
      end
    end
  end

endmodule
